chamber_pump_timer: RTL and testbench

CHAMBER_PUMP_TIMER -- requirements
Module: chamber_pump_timer

---
 rtl/chamber_pump_timer_pkg.sv | 24 ++
 rtl/sec_tick.sv | 37 +++
 rtl/chamber_pump_timer.sv | 142 ++++++++++++++
 tb/tb_chamber_pump_timer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chamber_pump_timer_pkg.sv
// Shared state encoding and active-low 7-segment images for the chamber pump timer.
// Segment bit order is {g, f, e, d, c, b, a}; a cleared bit lights the segment.
package chamber_pump_timer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StDrain,
        StWait,
        StDone
    } pumpState_e;

    localparam logic [6:0] SegBlank = 7'h7F;

    localparam logic [6:0] SegDigits [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] segImage(input logic [3:0] value);
        return SegDigits[value];
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, ticks on the last count.
// clear forces the count back to zero and wins over enable.
module sec_tick #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] countQ, countD;

    assign tick = enable && (countQ == LastCount);

    always_comb begin
        countD = countQ;
        if (clear) begin
            countD = '0;
        end else if (enable) begin
            countD = tick ? '0 : countQ + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

endmodule

// File: rtl/chamber_pump_timer.sv
// Timed fill/drain/equalise sequencer for the pressure chamber interlock.
// Optional macro CHAMBER_SEG_DISPLAY_EN adds the hexLeft 7-segment countdown output.
module chamber_pump_timer
    import chamber_pump_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned FILL_SECS  = 7,
    parameter int unsigned DRAIN_SECS = 8,
    parameter int unsigned WAIT_SECS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       filling,
    input  logic       draining,
    input  logic       waiting,
    output logic       fillFinished,
    output logic       drainFinished,
    output logic       waitFinished,
    output logic       pressureCheck,
    output logic       busy,
    output logic [3:0] secondsLeft
`ifdef CHAMBER_SEG_DISPLAY_EN
    ,
    output logic [6:0] hexLeft
`endif
);

    localparam logic [3:0] FillSecs  = 4'(FILL_SECS);
    localparam logic [3:0] DrainSecs = 4'(DRAIN_SECS);
    localparam logic [3:0] WaitSecs  = 4'(WAIT_SECS);

    pumpState_e stateQ, stateD;
    // Operation that owns the current run/DONE phase; selects which request keeps it alive.
    pumpState_e opQ, opD;
    logic [3:0] secsQ, secsD;
    logic       pressQ, pressD;
    logic       running, reqActive, tick;

    assign running = (stateQ == StFill) || (stateQ == StDrain) || (stateQ == StWait);

    always_comb begin
        reqActive = 1'b0;
        case (opQ)
            StFill:  reqActive = filling;
            StDrain: reqActive = draining;
            StWait:  reqActive = waiting;
            default: reqActive = 1'b0;
        endcase
    end

    sec_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .clear (!running),
        .enable(running && reqActive),
        .tick  (tick)
    );

    always_comb begin
        stateD = stateQ;
        opD    = opQ;
        secsD  = secsQ;
        pressD = pressQ;
        case (stateQ)
            StIdle: begin
                if (draining) begin
                    stateD = StDrain;
                    opD    = StDrain;
                    secsD  = DrainSecs;
                end else if (filling) begin
                    stateD = StFill;
                    opD    = StFill;
                    secsD  = FillSecs;
                end else if (waiting) begin
                    stateD = StWait;
                    opD    = StWait;
                    secsD  = WaitSecs;
                end
            end
            StFill, StDrain, StWait: begin
                if (!reqActive) begin
                    stateD = StIdle;
                    secsD  = '0;
                end else if (tick) begin
                    if (secsQ <= 4'd1) begin
                        stateD = StDone;
                        secsD  = '0;
                        if (opQ == StFill) begin
                            pressD = 1'b1;
                        end else if (opQ == StDrain) begin
                            pressD = 1'b0;
                        end
                    end else begin
                        secsD = secsQ - 4'd1;
                    end
                end
            end
            StDone: begin
                if (!reqActive) begin
                    stateD = StIdle;
                end
            end
            default: begin
                stateD = StIdle;
                secsD  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ <= StIdle;
            opQ    <= StIdle;
            secsQ  <= '0;
            pressQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            opQ    <= opD;
            secsQ  <= secsD;
            pressQ <= pressD;
        end
    end

    assign busy          = running;
    assign secondsLeft   = secsQ;
    assign pressureCheck = pressQ;
    assign fillFinished  = (stateQ == StDone) && (opQ == StFill);
    assign drainFinished = (stateQ == StDone) && (opQ == StDrain);
    assign waitFinished  = (stateQ == StDone) && (opQ == StWait);

`ifdef CHAMBER_SEG_DISPLAY_EN
    always_comb begin
        hexLeft = SegBlank;
        if (reset && (stateQ != StIdle)) begin
            hexLeft = segImage(secsQ);
        end
    end
`endif

endmodule

// File: tb/tb_chamber_pump_timer.sv
// Self-checking bench for chamber_pump_timer: directed scenarios plus a randomized run
// compared against an elapsed-time reference model.
module tb_chamber_pump_timer;

    localparam int unsigned CLK_HZ     = 4;
    localparam int unsigned FILL_SECS  = 3;
    localparam int unsigned DRAIN_SECS = 2;
    localparam int unsigned WAIT_SECS  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       filling, draining, waiting;
    logic       fillFinished, drainFinished, waitFinished;
    logic       pressureCheck, busy;
    logic [3:0] secondsLeft;
`ifdef CHAMBER_SEG_DISPLAY_EN
    logic [6:0] hexLeft;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 running, 2 done; op 0 fill, 1 drain, 2 wait.
    int mMode    = 0;
    int mOp      = 0;
    int mElapsed = 0;
    bit mPress   = 1'b0;

    always #5 clk = ~clk;

    chamber_pump_timer #(
        .CLK_HZ    (CLK_HZ),
        .FILL_SECS (FILL_SECS),
        .DRAIN_SECS(DRAIN_SECS),
        .WAIT_SECS (WAIT_SECS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .filling      (filling),
        .draining     (draining),
        .waiting      (waiting),
        .fillFinished (fillFinished),
        .drainFinished(drainFinished),
        .waitFinished (waitFinished),
        .pressureCheck(pressureCheck),
        .busy         (busy),
        .secondsLeft  (secondsLeft)
`ifdef CHAMBER_SEG_DISPLAY_EN
        ,
        .hexLeft      (hexLeft)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int secsOf(input int op);
        case (op)
            0:       return FILL_SECS;
            1:       return DRAIN_SECS;
            default: return WAIT_SECS;
        endcase
    endfunction

    function automatic bit reqOf(input int op);
        case (op)
            0:       return filling;
            1:       return draining;
            default: return waiting;
        endcase
    endfunction

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic modelEdge();
        if (!reset) begin
            mMode  = 0;
            mPress = 1'b0;
        end else if (mMode == 0) begin
            if (draining || filling || waiting) begin
                mOp      = draining ? 1 : (filling ? 0 : 2);
                mMode    = 1;
                mElapsed = 0;
            end
        end else if (mMode == 1) begin
            if (!reqOf(mOp)) begin
                mMode = 0;
            end else begin
                mElapsed++;
                if (mElapsed == secsOf(mOp) * CLK_HZ) begin
                    mMode = 2;
                    if (mOp == 0) mPress = 1'b1;
                    if (mOp == 1) mPress = 1'b0;
                end
            end
        end else if (!reqOf(mOp)) begin
            mMode = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; filling = 1'b0; draining = 1'b0; waiting = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (secondsLeft !== 4'd0) begin
            failures++; $display("FAIL reset_secs got=%0d exp=0", secondsLeft);
        end
        checks++;
        if ({fillFinished, drainFinished, waitFinished} !== 3'b000) begin
            failures++;
            $display("FAIL reset_finished got=%b exp=000",
                     {fillFinished, drainFinished, waitFinished});
        end
        checks++;
        if (pressureCheck !== 1'b0) begin
            failures++; $display("FAIL reset_pressure got=%b exp=0", pressureCheck);
        end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || secondsLeft !== 4'd0) begin
            failures++; $display("FAIL idle_after_reset busy=%b secs=%0d exp 0/0", busy, secondsLeft);
        end
    endtask

    task automatic test_fill();
        logic [3:0] expSecs;
        filling = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || secondsLeft !== 4'(FILL_SECS)) begin
            failures++;
            $display("FAIL fill_entry busy=%b secs=%0d exp 1/%0d", busy, secondsLeft, FILL_SECS);
        end
        for (int k = 1; k <= FILL_SECS * CLK_HZ; k++) begin
            step();
            expSecs = (k == FILL_SECS * CLK_HZ) ? 4'd0 : 4'(FILL_SECS - k / CLK_HZ);
            checks++;
            if (secondsLeft !== expSecs || fillFinished !== (k == FILL_SECS * CLK_HZ)) begin
                failures++;
                $display("FAIL fill_count cycle=%0d secs=%0d exp=%0d fin=%b", k, secondsLeft,
                         expSecs, fillFinished);
            end
        end
        checks++;
        if (pressureCheck !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL fill_done press=%b busy=%b exp 1/0", pressureCheck, busy);
        end
        step();
        step();
        checks++;
        if (fillFinished !== 1'b1) begin
            failures++; $display("FAIL fill_hold got=%b exp=1", fillFinished);
        end
        filling = 1'b0;
        step();
        checks++;
        if (fillFinished !== 1'b0 || busy !== 1'b0 || pressureCheck !== 1'b1) begin
            failures++;
            $display("FAIL fill_release fin=%b busy=%b press=%b exp 0/0/1", fillFinished, busy,
                     pressureCheck);
        end
    endtask

    task automatic test_drain();
        draining = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || secondsLeft !== 4'(DRAIN_SECS)) begin
            failures++;
            $display("FAIL drain_entry busy=%b secs=%0d exp 1/%0d", busy, secondsLeft, DRAIN_SECS);
        end
        for (int k = 1; k <= DRAIN_SECS * CLK_HZ; k++) begin
            step();
            checks++;
            if (drainFinished !== (k == DRAIN_SECS * CLK_HZ)) begin
                failures++;
                $display("FAIL drain_finish cycle=%0d got=%b", k, drainFinished);
            end
        end
        checks++;
        if (pressureCheck !== 1'b0) begin
            failures++; $display("FAIL drain_pressure got=%b exp=0", pressureCheck);
        end
        draining = 1'b0;
        step();
        checks++;
        if (drainFinished !== 1'b0) begin
            failures++; $display("FAIL drain_release got=%b exp=0", drainFinished);
        end
    endtask

    task automatic test_priority();
        filling = 1'b1; draining = 1'b1; waiting = 1'b1;
        step();
        checks++;
        if (secondsLeft !== 4'(DRAIN_SECS) || busy !== 1'b1) begin
            failures++;
            $display("FAIL prio_select secs=%0d busy=%b exp %0d/1", secondsLeft, busy, DRAIN_SECS);
        end
        for (int k = 1; k <= DRAIN_SECS * CLK_HZ + 3; k++) begin
            step();
            checks++;
            if (fillFinished !== 1'b0 || waitFinished !== 1'b0 ||
                drainFinished !== (k >= DRAIN_SECS * CLK_HZ)) begin
                failures++;
                $display("FAIL prio_finished cycle=%0d fdw=%b%b%b", k, fillFinished,
                         drainFinished, waitFinished);
            end
        end
        draining = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || {fillFinished, drainFinished, waitFinished} !== 3'b000) begin
            failures++; $display("FAIL prio_idle busy=%b exp=0", busy);
        end
        step();
        checks++;
        if (secondsLeft !== 4'(FILL_SECS) || busy !== 1'b1) begin
            failures++;
            $display("FAIL prio_next secs=%0d busy=%b exp %0d/1", secondsLeft, busy, FILL_SECS);
        end
        filling = 1'b0; waiting = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || secondsLeft !== 4'd0 || pressureCheck !== 1'b0) begin
            failures++;
            $display("FAIL prio_abort busy=%b secs=%0d press=%b exp 0/0/0", busy, secondsLeft,
                     pressureCheck);
        end
    endtask

    task automatic test_abort();
        filling = 1'b1;
        repeat (FILL_SECS * CLK_HZ + 1) step();
        filling = 1'b0;
        step();
        checks++;
        if (pressureCheck !== 1'b1) begin
            failures++; $display("FAIL abort_setup press=%b exp=1", pressureCheck);
        end
        waiting = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (waitFinished !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL abort_run cycle=%0d fin=%b busy=%b", k, waitFinished, busy);
            end
        end
        waiting = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || secondsLeft !== 4'd0 || waitFinished !== 1'b0 ||
            pressureCheck !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle busy=%b secs=%0d fin=%b press=%b exp 0/0/0/1", busy,
                     secondsLeft, waitFinished, pressureCheck);
        end
        repeat (WAIT_SECS * CLK_HZ) begin
            step();
            checks++;
            if (waitFinished !== 1'b0) begin
                failures++; $display("FAIL abort_no_pulse got=%b exp=0", waitFinished);
            end
        end
    endtask

    task automatic test_reset_midrun();
        filling = 1'b1;
        repeat (CLK_HZ + 1) step();
        checks++;
        if (secondsLeft !== 4'd2) begin
            failures++; $display("FAIL midrun_secs got=%0d exp=2", secondsLeft);
        end
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || secondsLeft !== 4'd0 || pressureCheck !== 1'b0 ||
            fillFinished !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset busy=%b secs=%0d press=%b fin=%b exp 0/0/0/0", busy,
                     secondsLeft, pressureCheck, fillFinished);
        end
        reset = 1'b1; filling = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL midrun_idle busy=%b exp=0", busy);
        end
    endtask

`ifdef CHAMBER_SEG_DISPLAY_EN
    task automatic test_display();
        filling = 1'b1;
        step();
        checks++;
        if (hexLeft !== 7'b0110000) begin
            failures++; $display("FAIL display_three got=%b exp=0110000", hexLeft);
        end
        filling = 1'b0;
        step();
        checks++;
        if (hexLeft !== 7'h7F) begin
            failures++; $display("FAIL display_blank got=%h exp=7f", hexLeft);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] expSecs;
        mMode = 0; mPress = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset = (i == 0 || $urandom_range(299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(29) == 0) begin
                {draining, filling, waiting} = 3'($urandom_range(7));
            end
            modelEdge();
            step();
            expSecs = (mMode == 1) ? 4'(secsOf(mOp) - mElapsed / CLK_HZ) : 4'd0;
            checks++;
            if (busy !== (mMode == 1) || secondsLeft !== expSecs ||
                pressureCheck !== mPress ||
                fillFinished !== (mMode == 2 && mOp == 0) ||
                drainFinished !== (mMode == 2 && mOp == 1) ||
                waitFinished !== (mMode == 2 && mOp == 2)) begin
                failures++;
                $display("FAIL random cycle=%0d busy=%b secs=%0d press=%b fdw=%b%b%b exp mode=%0d op=%0d secs=%0d press=%b",
                         i, busy, secondsLeft, pressureCheck, fillFinished, drainFinished,
                         waitFinished, mMode, mOp, expSecs, mPress);
            end
            checks++;
            if (32'(fillFinished) + 32'(drainFinished) + 32'(waitFinished) > 1) begin
                failures++; $display("FAIL one_finished cycle=%0d got more than one", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_priority();
        test_abort();
        test_reset_midrun();
`ifdef CHAMBER_SEG_DISPLAY_EN
        test_display();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
